// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the store read-modify-write path: size encodings,
// FSM state codes and the alignment check used at request acceptance.
package store_rmw_unit_pkg;

    localparam int unsigned SIZE_W  = 2;
    localparam int unsigned STATE_W = 3;

    // Store size encodings as carried on req_size.
    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
    localparam logic [SIZE_W-1:0] SZ_RSVD = 2'b11;

    // FSM state codes.
    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_READ  = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [STATE_W-1:0] ST_WRITE = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERR   = 3'd4;

    // True when the access is not naturally aligned or uses the reserved size.
    function automatic logic isMisaligned(input logic [SIZE_W-1:0] size,
                                          input logic [1:0]        offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            SZ_RSVD: bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: replaces the addressed byte/halfword of an old
// memory word with the low bits of the store data; word size passes data through.
// Ports:
//   oldWord      - word read back from memory
//   data         - register value being stored
//   size         - SZ_BYTE / SZ_HALF / SZ_WORD (reserved keeps oldWord)
//   offset       - byte offset within the word (addr[1:0])
//   mergedWord_c - resulting word to write
module store_lane_merge
    import store_rmw_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0]       oldWord,
    input  logic [31:0]       data,
    input  logic [SIZE_W-1:0] size,
    input  logic [1:0]        offset,
    output logic [31:0]       mergedWord_c
);

    logic [1:0] byteLane;
    logic       upperHalf;

    // Lane select counts from the LSB; big-endian offset 0 is the top byte.
    always_comb begin
        byteLane     = BIG_ENDIAN ? 2'(2'd3 - offset) : offset;
        upperHalf    = BIG_ENDIAN ? ~offset[1] : offset[1];
        mergedWord_c = oldWord;
        case (size)
            SZ_BYTE: mergedWord_c[{byteLane, 3'b000} +: 8] = data[7:0];
            SZ_HALF: begin
                if (upperHalf) begin
                    mergedWord_c[31:16] = data[15:0];
                end else begin
                    mergedWord_c[15:0] = data[15:0];
                end
            end
            SZ_WORD: mergedWord_c = data;
            default: mergedWord_c = oldWord;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store path between EX/MEM and a word-only data memory. Word stores issue a
// single write; byte/half stores read the word, merge the new lane(s) and
// write it back, stalling the requester through req_ready.
// Ports:
//   CLK, Reset            - clock, synchronous active-low reset
//   req_valid/req_ready   - request handshake (ready only while idle)
//   req_addr/data/size    - byte address, register value, size code
//   mem_addr              - word-aligned memory address (0 while idle)
//   mem_re / mem_rdata    - read strobe; data returns one cycle later
//   mem_we / mem_wdata    - one-cycle write strobe and merged word
//   done / err_misalign   - completion pulse, with error flag for bad requests
module store_rmw_unit
    import store_rmw_unit_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [SIZE_W-1:0] req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err_misalign
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] stateNext;

    logic [ADDR_W-1:0]  addrQ;
    logic [31:0]        dataQ;
    logic [SIZE_W-1:0]  sizeQ;

    logic               accept;
    logic [ADDR_W-1:0]  addrSel;
    logic [31:0]        mergedWord_c;

    logic               readyNext;
    logic               reNext;
    logic               weNext;
    logic               doneNext;
    logic               errNext;
    logic [ADDR_W-1:0]  memAddrNext;
    logic [31:0]        wdataNext;

    // Read data is live during WAIT, so the merge uses it directly and the
    // merged word lands in the mem_wdata register at the WAIT->WRITE edge.
    store_lane_merge #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) uMerge (
        .oldWord      (mem_rdata),
        .data         (dataQ),
        .size         (sizeQ),
        .offset       (addrQ[1:0]),
        .mergedWord_c (mergedWord_c)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and next-cycle output values (outputs follow the next state).
    always_comb begin
        stateNext   = state;
        accept      = req_valid && req_ready;
        addrSel     = accept ? req_addr : addrQ;
        readyNext   = 1'b0;
        reNext      = 1'b0;
        weNext      = 1'b0;
        doneNext    = 1'b0;
        errNext     = 1'b0;
        memAddrNext = '0;
        wdataNext   = '0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (isMisaligned(req_size, req_addr[1:0])) begin
                        stateNext = ST_ERR;
                    end else if (req_size == SZ_WORD) begin
                        stateNext = ST_WRITE;
                    end else begin
                        stateNext = ST_READ;
                    end
                end
            end
            ST_READ:  stateNext = ST_WAIT;
            ST_WAIT:  stateNext = ST_WRITE;
            ST_WRITE: stateNext = ST_IDLE;
            ST_ERR:   stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase

        readyNext = (stateNext == ST_IDLE);
        reNext    = (stateNext == ST_READ);
        weNext    = (stateNext == ST_WRITE);
        errNext   = (stateNext == ST_ERR);
        doneNext  = weNext || errNext;

        if (reNext || weNext || (stateNext == ST_WAIT)) begin
            memAddrNext = addrSel & ~ADDR_W'(3);
        end
        // Word stores go straight from IDLE to WRITE with the raw register value.
        if (weNext) begin
            wdataNext = (state == ST_IDLE) ? req_data : mergedWord_c;
        end
    end

    // Registered outputs and latched request.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            req_ready    <= 1'b0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            done         <= 1'b0;
            err_misalign <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            addrQ        <= '0;
            dataQ        <= '0;
            sizeQ        <= '0;
        end else begin
            req_ready    <= readyNext;
            mem_re       <= reNext;
            mem_we       <= weNext;
            done         <= doneNext;
            err_misalign <= errNext;
            mem_addr     <= memAddrNext;
            mem_wdata    <= wdataNext;
            if (accept) begin
                addrQ <= req_addr;
                dataQ <= req_data;
                sizeQ <= req_size;
            end
        end
    end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench: one big-endian and one little-endian instance share the
// request inputs, each with its own word memory; a byte-addressed reference
// model predicts strobes, latency and the stored words.
module tb_store_rmw_unit;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } req_t;

    logic        CLK;
    logic        Reset;
    logic        reqValid;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic [1:0]  reqSize;

    logic [1:0]  reqReady;
    logic [1:0]  memRe;
    logic [1:0]  memWe;
    logic [1:0]  doneP;
    logic [1:0]  errMis;
    logic [31:0] memAddr  [2];
    logic [31:0] memWdata [2];

    logic        preWe;
    logic [5:0]  preIdx;
    logic [31:0] preVal;

    logic [31:0] refMem [2][64];
    logic [31:0] noWd [2];

    int checks;
    int failures;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Index 0: little-endian instance, index 1: big-endian instance.
    for (genvar e = 0; e < 2; e++) begin : g
        logic [31:0] mem [64];
        logic [31:0] rdata;
        int          weCount = 0;

        store_rmw_unit #(
            .ADDR_W     (32),
            .BIG_ENDIAN (e == 1)
        ) dut (
            .CLK          (CLK),
            .Reset        (Reset),
            .req_valid    (reqValid),
            .req_ready    (reqReady[e]),
            .req_addr     (reqAddr),
            .req_data     (reqData),
            .req_size     (reqSize),
            .mem_addr     (memAddr[e]),
            .mem_re       (memRe[e]),
            .mem_rdata    (rdata),
            .mem_we       (memWe[e]),
            .mem_wdata    (memWdata[e]),
            .done         (doneP[e]),
            .err_misalign (errMis[e])
        );

        always @(posedge CLK) begin
            if (preWe) begin
                mem[preIdx] <= preVal;
            end else if (memWe[e]) begin
                mem[memAddr[e][7:2]] <= memWdata[e];
            end
            if (memRe[e]) begin
                rdata <= mem[memAddr[e][7:2]];
            end
            if (memWe[e]) begin
                weCount <= weCount + 1;
            end
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic req_t mkReq(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_t r;
        r.addr = a;
        r.data = d;
        r.size = s;
        return r;
    endfunction

    // Access is bad when the size is reserved or the address is not a multiple of its byte count.
    function automatic bit refMis(input req_t r);
        int nBytes;
        nBytes = 1 << r.size;
        return (r.size == 2'b11) || ((int'(r.addr) % nBytes) != 0);
    endfunction

    // Store the n low data bytes to consecutive byte addresses, then view the
    // word through the chosen byte order.
    function automatic logic [31:0] refMerge(input logic [31:0] oldW, input req_t r, input bit be);
        int          n;
        int          off;
        int          dataByte;
        int          memByte;
        int          pos;
        logic [7:0]  b;
        logic [31:0] w;
        n   = 1 << r.size;
        off = int'(r.addr[1:0]);
        w   = oldW;
        for (int i = 0; i < n; i++) begin
            dataByte = be ? (n - 1 - i) : i;
            memByte  = off + i;
            pos      = be ? (3 - memByte) : memByte;
            b        = 8'(r.data >> (8 * dataByte));
            w        = (w & ~(32'hFF << (8 * pos))) | (32'(b) << (8 * pos));
        end
        return w;
    endfunction

    task automatic checkOut(input string tag, input int k, input bit expReady, input bit expRe,
                            input bit expWe, input bit expDone, input bit expErr,
                            input logic [31:0] expAddr, input logic [31:0] expWd [2]);
        for (int u = 0; u < 2; u++) begin
            checkEq($sformatf("%s.k%0d.e%0d.ready", tag, k, u), 32'(reqReady[u]), 32'(expReady));
            checkEq($sformatf("%s.k%0d.e%0d.re", tag, k, u), 32'(memRe[u]), 32'(expRe));
            checkEq($sformatf("%s.k%0d.e%0d.we", tag, k, u), 32'(memWe[u]), 32'(expWe));
            checkEq($sformatf("%s.k%0d.e%0d.done", tag, k, u), 32'(doneP[u]), 32'(expDone));
            checkEq($sformatf("%s.k%0d.e%0d.err", tag, k, u), 32'(errMis[u]), 32'(expErr));
            checkEq($sformatf("%s.k%0d.e%0d.addr", tag, k, u), memAddr[u], expAddr);
            if (expWe) begin
                checkEq($sformatf("%s.k%0d.e%0d.wdata", tag, k, u), memWdata[u], expWd[u]);
            end
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        preWe  = 1'b1;
        preIdx = 6'(idx);
        preVal = v;
        step();
        preWe = 1'b0;
        refMem[0][idx] = v;
        refMem[1][idx] = v;
    endtask

    // Present a request, follow it to completion and check every cycle.
    task automatic doStore(input string tag, input req_t r, input bit chain, input req_t nx);
        int          waited;
        int          lat;
        int          idx;
        bit          mis;
        bit          isWord;
        logic [31:0] wa;
        logic [31:0] expWd [2];
        reqValid = 1'b1;
        reqAddr  = r.addr;
        reqData  = r.data;
        reqSize  = r.size;
        waited   = 0;
        while (reqReady !== 2'b11 && waited < 20) begin
            step();
            waited++;
        end
        checkEq({tag, ".accept_wait"}, 32'(waited), 32'd0);
        if (reqReady !== 2'b11) begin
            reqValid = 1'b0;
            return;
        end
        mis    = refMis(r);
        isWord = (r.size == 2'b10);
        lat    = (mis || isWord) ? 1 : 3;
        wa     = {r.addr[31:2], 2'b00};
        idx    = int'(r.addr[7:2]);
        for (int u = 0; u < 2; u++) begin
            expWd[u] = mis ? 32'd0 : refMerge(refMem[u][idx], r, u == 1);
            if (!mis) refMem[u][idx] = expWd[u];
        end
        step();
        if (chain) begin
            reqAddr = nx.addr;
            reqData = nx.data;
            reqSize = nx.size;
        end else begin
            reqValid = 1'b0;
            reqAddr  = $urandom;
            reqData  = $urandom;
            reqSize  = 2'($urandom);
        end
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) step();
            checkOut(tag, k, 1'b0, !mis && !isWord && k == 1, !mis && k == lat,
                     k == lat, mis && k == 1, mis ? 32'd0 : wa, expWd);
        end
        step();
        checkOut({tag, ".post"}, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, expWd);
    endtask

    initial begin
        req_t cur;
        req_t nx;
        req_t none;
        bit   chain;
        int   w0;
        int   w1;

        checks   = 0;
        failures = 0;
        Reset    = 1'b0;
        reqValid = 1'b0;
        reqAddr  = '0;
        reqData  = '0;
        reqSize  = '0;
        preWe    = 1'b0;
        preIdx   = '0;
        preVal   = '0;
        none     = mkReq(32'd0, 32'd0, 2'b00);

        // Reset: everything low, ready only after release.
        repeat (2) step();
        checkOut("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, noWd);
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        Reset = 1'b1;
        checkOut("rel0", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, noWd);
        step();
        checkOut("rel1", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, noWd);

        // Directed word / byte / half stores.
        preload(8, 32'h0000_0000);
        doStore("sw", mkReq(32'h20, 32'hCAFE_F00D, 2'b10), 1'b0, none);
        checkEq("sw.mem.be", g[1].mem[8], 32'hCAFE_F00D);
        checkEq("sw.mem.le", g[0].mem[8], 32'hCAFE_F00D);

        preload(4, 32'h1122_3344);
        doStore("sb", mkReq(32'h11, 32'hFFFF_FFAB, 2'b00), 1'b0, none);
        checkEq("sb.mem.be", g[1].mem[4], 32'h11AB_3344);
        checkEq("sb.mem.le", g[0].mem[4], 32'h1122_AB44);

        preload(4, 32'h1122_3344);
        doStore("sh2", mkReq(32'h12, 32'hDEAD_BEEF, 2'b01), 1'b0, none);
        checkEq("sh2.mem.be", g[1].mem[4], 32'h1122_BEEF);
        checkEq("sh2.mem.le", g[0].mem[4], 32'hBEEF_3344);

        preload(4, 32'h1122_3344);
        doStore("sh0", mkReq(32'h10, 32'hDEAD_BEEF, 2'b01), 1'b0, none);
        checkEq("sh0.mem.be", g[1].mem[4], 32'hBEEF_3344);
        checkEq("sh0.mem.le", g[0].mem[4], 32'h1122_BEEF);

        // Misaligned and reserved-size requests.
        w0 = g[0].weCount;
        w1 = g[1].weCount;
        doStore("mis_sw", mkReq(32'h13, 32'h1234_5678, 2'b10), 1'b0, none);
        doStore("mis_sh", mkReq(32'h11, 32'h1234_5678, 2'b01), 1'b0, none);
        doStore("mis_rs", mkReq(32'h10, 32'h1234_5678, 2'b11), 1'b0, none);
        checkEq("mis.we.le", 32'(g[0].weCount - w0), 32'd0);
        checkEq("mis.we.be", 32'(g[1].weCount - w1), 32'd0);

        // Back-to-back: sb then sw with req_valid held high.
        preload(4, 32'h1122_3344);
        w0 = g[0].weCount;
        w1 = g[1].weCount;
        doStore("b2b1", mkReq(32'h11, 32'h0000_00AB, 2'b00), 1'b1, mkReq(32'h40, 32'h1234_5678, 2'b10));
        doStore("b2b2", mkReq(32'h40, 32'h1234_5678, 2'b10), 1'b0, none);
        checkEq("b2b.we.le", 32'(g[0].weCount - w0), 32'd2);
        checkEq("b2b.we.be", 32'(g[1].weCount - w1), 32'd2);

        // Randomized stores, sometimes chained.
        cur = mkReq(32'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)));
        for (int i = 0; i < 300; i++) begin
            nx    = mkReq(32'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)));
            chain = 1'($urandom_range(0, 1));
            doStore("rnd", cur, chain, nx);
            cur = nx;
        end

        // Reset during WAIT aborts the store.
        w0 = g[0].weCount;
        w1 = g[1].weCount;
        checkEq("rst.ready", 32'(reqReady), 32'd3);
        reqValid = 1'b1;
        reqAddr  = 32'h35;
        reqData  = 32'h0000_0077;
        reqSize  = 2'b00;
        step();
        reqValid = 1'b0;
        checkOut("rst", 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h34, noWd);
        step();
        checkOut("rst", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h34, noWd);
        Reset = 1'b0;
        step();
        checkOut("rst.low", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, noWd);
        step();
        checkOut("rst.low", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, noWd);
        Reset = 1'b1;
        step();
        checkOut("rst.up", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, noWd);
        checkEq("rst.we.le", 32'(g[0].weCount - w0), 32'd0);
        checkEq("rst.we.be", 32'(g[1].weCount - w1), 32'd0);

        // Final memory image against the reference.
        for (int i = 0; i < 64; i++) begin
            checkEq($sformatf("mem.le[%0d]", i), g[0].mem[i], refMem[0][i]);
            checkEq($sformatf("mem.be[%0d]", i), g[1].mem[i], refMem[1][i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
